// File: rtl/counter_sequencer.sv
// Start/stop/hold sequencer for a WIDTH-bit up-counter with programmable terminal value.
// Optional PRESCALE_EN: count ticks come from a PRESCALE_DIV-cycle divider instead of every clock.
module counter_sequencer #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  // state | meaning
  // IDLE  | counter cleared, waiting for start
  // RUN   | counting toward the latched terminal value
  // DONE  | one-shot run finished, count parked at terminal
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] term;
  logic             mode;
  logic             tick;

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_div
    $error("PRESCALE_DIV must be in 2..256");
  end

`ifdef PRESCALE_EN
  localparam int DIV_W = $clog2(PRESCALE_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(PRESCALE_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Down-counter reloaded on start so the first tick lands PRESCALE_DIV cycles later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_LOAD;
    end else if (stop || start) begin
      div_cnt <= DIV_LOAD;
    end else if (state == RUN && !hold) begin
      if (div_cnt == '0) div_cnt <= DIV_LOAD;
      else               div_cnt <= div_cnt - 1'b1;
    end
  end

  assign tick = (div_cnt == '0);
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      tc    <= 1'b0;
      done  <= 1'b0;
      term  <= '0;
      mode  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      state <= RUN;
      count <= '0;
      busy  <= 1'b1;
      tc    <= 1'b0;
      done  <= 1'b0;
      term  <= terminal;
      mode  <= auto_reload;
    end else begin
      tc <= 1'b0;
      if (state == RUN && !hold && tick) begin
        if (count == term) begin
          tc <= 1'b1;
          if (mode) begin
            count <= '0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
